// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use hazard control feeding the EX-stage forwarding mux.
// Optional stall/forward statistics counters are enabled with `define FWD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int REGADDR_W = 5,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REGADDR_W-1:0] id_rs1,
  input  logic [REGADDR_W-1:0] id_rs2,
  input  logic                 id_use_rs2,
  input  logic [REGADDR_W-1:0] id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_memread,
  input  logic                 id_asel,
  input  logic                 flush,
  output logic [1:0]           ex_muxsel_a,
  output logic [1:0]           ex_muxsel_b,
  output logic                 ex_asel,
  output logic                 ex_valid,
  output logic                 stall,
  output logic [STAT_W-1:0]    stall_cnt,
  output logic [STAT_W-1:0]    fwd_cnt
);

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic                 memread;
    logic [REGADDR_W-1:0] rd;
    logic [1:0]           muxsel_a;
    logic [1:0]           muxsel_b;
    logic                 asel;
  } rec_t;

  localparam int NSTAGE = 3;  // 0 = EX, 1 = MEM, 2 = WB

  rec_t stage_reg [NSTAGE];
  rec_t ex_next;

  logic [1:0][REGADDR_W-1:0] src_rs;
  logic [1:0]                match;
  logic [1:0]                hit_ex;
  logic [1:0]                hit_mem;
  logic [1:0][1:0]           sel;
  logic                      stall_int;
  logic                      load_id;

  assign src_rs[0] = id_rs1;
  assign src_rs[1] = id_rs2;
  assign match[0]  = id_valid & ~id_asel & (id_rs1 != '0);
  assign match[1]  = id_valid & id_use_rs2 & (id_rs2 != '0);

  // Youngest producer wins: EX result is on the ALU path next cycle, MEM's on WB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign hit_ex[gi]  = stage_reg[0].valid & stage_reg[0].regwrite & (stage_reg[0].rd == src_rs[gi]);
      assign hit_mem[gi] = stage_reg[1].valid & stage_reg[1].regwrite & (stage_reg[1].rd == src_rs[gi]);
      assign sel[gi]     = !match[gi]  ? 2'b00 :
                           hit_ex[gi]  ? 2'b10 :
                           hit_mem[gi] ? 2'b01 : 2'b00;
    end
  endgenerate

  assign stall_int = ~flush & stage_reg[0].valid & stage_reg[0].memread & (stage_reg[0].rd != '0) &
                     ((match[0] & (stage_reg[0].rd == id_rs1)) |
                      (match[1] & (stage_reg[0].rd == id_rs2)));
  assign load_id   = ~flush & ~stall_int & id_valid;

  always_comb begin
    ex_next = '0;
    if (load_id) begin
      ex_next.valid    = 1'b1;
      ex_next.regwrite = id_regwrite;
      ex_next.memread  = id_memread;
      ex_next.rd       = id_rd;
      ex_next.muxsel_a = sel[0];
      ex_next.muxsel_b = sel[1];
      ex_next.asel     = id_asel;
    end
  end

  // EX/MEM/WB always advance; a stall only replaces the EX load with a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTAGE; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= ex_next;
      for (int i = 1; i < NSTAGE; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign ex_muxsel_a = stage_reg[0].muxsel_a;
  assign ex_muxsel_b = stage_reg[0].muxsel_b;
  assign ex_asel     = stage_reg[0].asel;
  assign ex_valid    = stage_reg[0].valid;
  assign stall       = stall_int;

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_reg;
  logic [STAT_W-1:0] fwd_cnt_reg;
  logic [1:0]        fwd_inc;
  logic [STAT_W:0]   fwd_sum;

  assign fwd_inc = {1'b0, (ex_next.muxsel_a != 2'b00)} + {1'b0, (ex_next.muxsel_b != 2'b00)};
  assign fwd_sum = {1'b0, fwd_cnt_reg} + {{(STAT_W-1){1'b0}}, fwd_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (stall_int && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      fwd_cnt_reg <= fwd_sum[STAT_W] ? '1 : fwd_sum[STAT_W-1:0];
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign fwd_cnt   = fwd_cnt_reg;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl: forwarding selects, load-use stall, flush and reset.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_asel;
  logic        flush;
  logic [1:0]  ex_muxsel_a;
  logic [1:0]  ex_muxsel_b;
  logic        ex_asel;
  logic        ex_valid;
  logic        stall;
  logic [15:0] stall_cnt;
  logic [15:0] fwd_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] stall_snap;
  logic [15:0] fwd_snap;

  fwd_hazard_ctrl #(.REGADDR_W(5), .STAT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_asel(id_asel),
    .flush(flush),
    .ex_muxsel_a(ex_muxsel_a), .ex_muxsel_b(ex_muxsel_b), .ex_asel(ex_asel),
    .ex_valid(ex_valid), .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  // valid, rs1, rs2, use_rs2, rd, regwrite, memread, asel
  task automatic put(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                     input logic [4:0] d, input logic rw, input logic mr, input logic as);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = d; id_regwrite = rw; id_memread = mr; id_asel = as;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("rst_sel_a", 16'(ex_muxsel_a), 16'h0);
    chk("rst_sel_b", 16'(ex_muxsel_b), 16'h0);
    chk("rst_valid", 16'(ex_valid), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);
    chk("rst_fwd_cnt", fwd_cnt, 16'h0);
    rst = 1'b0;
    step();

    // add x5, x1, x2 ; sub x6, x5, x1
    put(1, 1, 2, 1, 5, 1, 0, 0); step();
    chk("b2b_prod_valid", 16'(ex_valid), 16'h1);
    chk("b2b_prod_sel_a", 16'(ex_muxsel_a), 16'h0);
    put(1, 5, 1, 1, 6, 1, 0, 0);
    #1 chk("b2b_no_stall", 16'(stall), 16'h0);
    step();
    chk("b2b_sel_a", 16'(ex_muxsel_a), 16'h2);
    chk("b2b_sel_b", 16'(ex_muxsel_b), 16'h0);
    drain();

    // add x5 ; nop ; or x7, x1, x5
    put(1, 1, 2, 1, 5, 1, 0, 0); step();
    put(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("d2_nop_valid", 16'(ex_valid), 16'h0);
    put(1, 1, 5, 1, 7, 1, 0, 0); step();
    chk("d2_sel_a", 16'(ex_muxsel_a), 16'h0);
    chk("d2_sel_b", 16'(ex_muxsel_b), 16'h1);
    drain();

    // add x5 ; add x5 ; sub x8, x5, x5
    put(1, 1, 2, 1, 5, 1, 0, 0); step();
    step();
    put(1, 5, 5, 1, 8, 1, 0, 0); step();
    chk("dbl_sel_a", 16'(ex_muxsel_a), 16'h2);
    chk("dbl_sel_b", 16'(ex_muxsel_b), 16'h2);
    chk("dbl_asel", 16'(ex_asel), 16'h0);
    drain();

    // same with operand A taken from the PC
    put(1, 1, 2, 1, 5, 1, 0, 0); step();
    step();
    put(1, 5, 5, 1, 8, 1, 0, 1); step();
    chk("dbl_pc_sel_a", 16'(ex_muxsel_a), 16'h0);
    chk("dbl_pc_sel_b", 16'(ex_muxsel_b), 16'h2);
    chk("dbl_pc_asel", 16'(ex_asel), 16'h1);
    drain();

    // lw x7, 0(x1) ; add x9, x7, x2
    stall_snap = stall_cnt; fwd_snap = fwd_cnt;
    put(1, 1, 0, 0, 7, 1, 1, 0); step();
    put(1, 7, 2, 1, 9, 1, 0, 0);
    #1 chk("lu_stall", 16'(stall), 16'h1);
    step();
    chk("lu_bubble_valid", 16'(ex_valid), 16'h0);
    chk("lu_stall_one_cycle", 16'(stall), 16'h0);
    step();
    chk("lu_retry_valid", 16'(ex_valid), 16'h1);
    chk("lu_retry_sel_a", 16'(ex_muxsel_a), 16'h1);
    chk("lu_retry_sel_b", 16'(ex_muxsel_b), 16'h0);
`ifdef FWD_STATS_EN
    chk("lu_stall_cnt", stall_cnt - stall_snap, 16'h1);
    chk("lu_fwd_cnt", fwd_cnt - fwd_snap, 16'h1);
`else
    chk("lu_stall_cnt_off", stall_cnt, 16'h0);
    chk("lu_fwd_cnt_off", fwd_cnt, 16'h0);
`endif
    drain();

    // add x0 ; sub x1, x0, x0
    put(1, 1, 2, 1, 0, 1, 0, 0); step();
    put(1, 0, 0, 1, 1, 1, 0, 0); step();
    chk("x0_sel_a", 16'(ex_muxsel_a), 16'h0);
    chk("x0_sel_b", 16'(ex_muxsel_b), 16'h0);
    chk("x0_valid", 16'(ex_valid), 16'h1);
    drain();

    // lw x7 ; dependent add with flush in the would-be stall cycle
    put(1, 1, 0, 0, 7, 1, 1, 0); step();
    put(1, 7, 2, 1, 9, 1, 0, 0);
    flush = 1'b1;
    #1 chk("flush_kills_stall", 16'(stall), 16'h0);
    step();
    chk("flush_bubble", 16'(ex_valid), 16'h0);
    chk("flush_bubble_sel_a", 16'(ex_muxsel_a), 16'h0);
    flush = 1'b0;
    drain();

    // add x5 ; lw x7, 0(x5) ; add x9, x7, x2 then async reset mid-stall
    put(1, 1, 2, 1, 5, 1, 0, 0); step();
    put(1, 5, 0, 0, 7, 1, 1, 0); step();
    chk("pre_rst_lw_sel_a", 16'(ex_muxsel_a), 16'h2);
    put(1, 7, 2, 1, 9, 1, 0, 0);
    #1 chk("pre_rst_stall", 16'(stall), 16'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_stall", 16'(stall), 16'h0);
    chk("async_rst_valid", 16'(ex_valid), 16'h0);
    chk("async_rst_sel_a", 16'(ex_muxsel_a), 16'h0);
    chk("async_rst_sel_b", 16'(ex_muxsel_b), 16'h0);
    step();
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
